tank_ctrl: RTL and testbench

//  Per-player tank motion/fire controller between the joystick front-end and the VGA renderer.

---
 rtl/tank_pkg.sv | 33 +++
 rtl/tank_tick_gen.sv | 27 ++
 rtl/tank_ctrl.sv | 149 ++++++++++++++
 tb/tb_tank_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// tank_pkg: shared types and constants for the tank controller (headings, game states, FSM states, overlap helper).
package tank_pkg;
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_COMMIT
  } state_t;

  localparam logic [1:0] ST_TITLE = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam int MAP_W_DEF = 40;
  localparam int MAP_H_DEF = 30;

  // Tanks occupy 2x2 cells, so two tanks collide when both axis distances are below 2.
  function automatic logic overlap(input logic [5:0] ax, input logic [5:0] ay,
                                   input logic [5:0] bx, input logic [5:0] by);
    logic signed [6:0] dx, dy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    return (dx >= -7'sd1) && (dx <= 7'sd1) && (dy >= -7'sd1) && (dy <= 7'sd1);
  endfunction
endpackage

// File: rtl/tank_tick_gen.sv
// tank_tick_gen: motion-rate counter emitting a one-cycle tick every PERIOD enabled cycles.
//  clk     in  clock
//  rst_n   in  synchronous active-low reset
//  en_i    in  count enable (counter frozen when low)
//  clr_i   in  synchronous clear to 0
//  tick_o  out high in the enabled cycle where the count is PERIOD-1
module tank_tick_gen #(
  parameter int PERIOD = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(PERIOD - 1));

  always_comb cnt_d = clr_i ? '0 : tick_o ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;

  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tank_ctrl.sv
// tank_ctrl: per-player tank motion/fire controller producing grid position, heading and a fire pulse.
//  clk, rst_n                    clock, synchronous active-low reset
//  i_top_state                   game state (TITLE/PLAY/PAUSE/OVER)
//  i_VGA_buzy                    renderer busy, blocks move commit
//  i_up/i_down/i_left/i_right    joystick levels, priority up>down>left>right
//  i_fire                        fire button level
//  i_other_x/i_other_y           opponent position
//  o_x/o_y/o_dir                 tank position and heading
//  o_fire                        one-cycle shot request
//  o_moving                      high in the cycle a move/turn is committed
// Build option TANK_CTRL_WRAP_EN: off-grid moves wrap to the opposite border instead of being rejected.
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int   MAP_W       = MAP_W_DEF,
  parameter int   MAP_H       = MAP_H_DEF,
  parameter int   INIT_X      = 2,
  parameter int   INIT_Y      = 2,
  parameter dir_t INIT_DIR    = DIR_DOWN,
  parameter int   MOVE_PERIOD = 2_500_000,
  parameter int   FIRE_CD     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_top_state,
  input  logic       i_VGA_buzy,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_fire,
  input  logic [5:0] i_other_x,
  input  logic [5:0] i_other_y,
  output logic [5:0] o_x,
  output logic [5:0] o_y,
  output logic [1:0] o_dir,
  output logic       o_fire,
  output logic       o_moving
);
  localparam int CDW = $clog2(FIRE_CD + 1);
  localparam logic signed [6:0] XMAX = 7'(MAP_W - 2);
  localparam logic signed [6:0] YMAX = 7'(MAP_H - 2);

  state_t state_q, state_d;
  dir_t sel, dir_q, dir_d, cdir_q, cdir_d;
  logic [5:0] x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d, ox_q, ox_d, oy_q, oy_d, mx, my;
  logic [CDW-1:0] cd_q, cd_d;
  logic signed [6:0] nx, ny;
  logic play, title, tick, any_dir, turn, load, accept, mok;
  logic turn_q, turn_d, ok_q, ok_d, fire_q, fire_d, fprev_q;

  assign play    = i_top_state == ST_PLAY;
  assign title   = i_top_state == ST_TITLE;
  assign any_dir = i_up | i_down | i_left | i_right;
  assign sel     = i_up ? DIR_UP : i_down ? DIR_DOWN : i_left ? DIR_LEFT : DIR_RIGHT;
  assign turn    = sel != dir_q;

  tank_tick_gen #(.PERIOD(MOVE_PERIOD)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (play),
    .clr_i (title),
    .tick_o(tick)
  );

  always_comb
    state_d = !play               ? S_IDLE :
              state_q == S_IDLE   ? S_RUN :
              state_q == S_RUN    ? ((tick && any_dir) ? S_PEND : S_RUN) :
              state_q == S_PEND   ? (i_VGA_buzy ? S_PEND : S_COMMIT) :
                                    S_RUN;

  // One-cell step along the current heading, signed so a step off the top/left edge shows as -1.
  always_comb begin
    nx = $signed({1'b0, x_q}) + (dir_q == DIR_RIGHT ? 7'sd1 : dir_q == DIR_LEFT ? -7'sd1 : 7'sd0);
    ny = $signed({1'b0, y_q}) + (dir_q == DIR_DOWN ? 7'sd1 : dir_q == DIR_UP ? -7'sd1 : 7'sd0);
`ifdef TANK_CTRL_WRAP_EN
    mx  = (nx < 0) ? 6'(XMAX) : (nx > XMAX) ? 6'd0 : nx[5:0];
    my  = (ny < 0) ? 6'(YMAX) : (ny > YMAX) ? 6'd0 : ny[5:0];
    mok = 1'b1;
`else
    mx  = nx[5:0];
    my  = ny[5:0];
    mok = (nx >= 0) && (nx <= XMAX) && (ny >= 0) && (ny <= YMAX);
`endif
  end

  // The request is frozen at the tick: target, heading and the opponent's position at that moment.
  // The opponent test runs in COMMIT against the frozen copy, so later opponent motion cannot change it.
  always_comb begin
    load   = (state_q == S_RUN) && tick && any_dir;
    turn_d = load ? turn : turn_q;
    ok_d   = load ? (turn | mok) : ok_q;
    cdir_d = load ? sel : cdir_q;
    cx_d   = load ? (turn ? x_q : mx) : cx_q;
    cy_d   = load ? (turn ? y_q : my) : cy_q;
    ox_d   = load ? i_other_x : ox_q;
    oy_d   = load ? i_other_y : oy_q;
    accept = (state_q == S_COMMIT) && play && (turn_q || (ok_q && !overlap(cx_q, cy_q, ox_q, oy_q)));
    x_d    = title ? 6'(INIT_X) : accept ? cx_q : x_q;
    y_d    = title ? 6'(INIT_Y) : accept ? cy_q : y_q;
    dir_d  = title ? INIT_DIR : accept ? cdir_q : dir_q;
  end

  always_comb begin
    fire_d = play && i_fire && !fprev_q && (cd_q == '0);
    cd_d   = title ? '0 : fire_d ? CDW'(FIRE_CD) : (tick && cd_q != '0) ? cd_q - CDW'(1) : cd_q;
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= 6'(INIT_X);
      y_q     <= 6'(INIT_Y);
      dir_q   <= INIT_DIR;
      cdir_q  <= DIR_UP;
      cx_q    <= '0;
      cy_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      turn_q  <= 1'b0;
      ok_q    <= 1'b0;
      cd_q    <= '0;
      fire_q  <= 1'b0;
      fprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      cdir_q  <= cdir_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      turn_q  <= turn_d;
      ok_q    <= ok_d;
      cd_q    <= cd_d;
      fire_q  <= fire_d;
      fprev_q <= i_fire;
    end

  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_dir    = dir_q;
  // A shot latched in the last PLAY cycle is suppressed if the game has just left PLAY.
  assign o_fire   = fire_q && play;
  assign o_moving = accept;
endmodule

// File: tb/tb_tank_ctrl.sv
// tb_tank_ctrl: table-driven scoreboard bench for tank_ctrl (MOVE_PERIOD=4, FIRE_CD=2).
module tb_tank_ctrl;
  import tank_pkg::*;
`ifdef TANK_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [3:0] NO = 4'b0000, R = 4'b0001, L = 4'b0010, D = 4'b0100;
  localparam logic [1:0] PL = ST_PLAY, TI = ST_TITLE, PA = ST_PAUSE;
  typedef struct {
    int          n;
    logic [1:0]  ts;
    logic [1:0]  es;
    logic        bz;
    logic [3:0]  dirs;
    logic        f;
    logic [5:0]  ox;
    logic [5:0]  oy;
    logic        ed;
    logic [15:0] exp;
  } vec_t;
  typedef struct {
    logic        ed;
    logic [15:0] exp;
    int          id;
  } sb_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] ts = PL, es = TI;
  logic bz = 1'b0, up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0, fi = 1'b0;
  logic [5:0] ox = 6'd20, oy = 6'd20;
  logic [5:0] ax, ay, bx, by;
  logic [1:0] ad, bd;
  logic af, am, bf, bm;
  vec_t tbl[$];
  sb_t sb[$];
  sb_t s;
  logic [15:0] act;
  int checks = 0, failures = 0, id = 0;
  always #5 clk = ~clk;
  tank_ctrl #(.MOVE_PERIOD(4), .FIRE_CD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_top_state(ts), .i_VGA_buzy(bz),
    .i_up(up), .i_down(dn), .i_left(lf), .i_right(rt), .i_fire(fi),
    .i_other_x(ox), .i_other_y(oy),
    .o_x(ax), .o_y(ay), .o_dir(ad), .o_fire(af), .o_moving(am)
  );
  tank_ctrl #(.INIT_X(38), .INIT_DIR(DIR_RIGHT), .MOVE_PERIOD(4), .FIRE_CD(2)) u_edge (
    .clk(clk), .rst_n(rst_n), .i_top_state(es), .i_VGA_buzy(bz),
    .i_up(up), .i_down(dn), .i_left(lf), .i_right(rt), .i_fire(fi),
    .i_other_x(ox), .i_other_y(oy),
    .o_x(bx), .o_y(by), .o_dir(bd), .o_fire(bf), .o_moving(bm)
  );
  function automatic logic [15:0] e(input int x, input int y, input dir_t d, input logic f, input logic m);
    return {6'(x), 6'(y), d, f, m};
  endfunction
  function automatic vec_t v(input int n, input logic [1:0] t, input logic [1:0] t2, input logic b,
                             input logic [3:0] dirs, input logic f, input logic [5:0] x, input logic [5:0] y,
                             input logic ed, input logic [15:0] ex);
    vec_t r;
    r.n = n; r.ts = t; r.es = t2; r.bz = b; r.dirs = dirs; r.f = f;
    r.ox = x; r.oy = y; r.ed = ed; r.exp = ex;
    return r;
  endfunction
  task automatic drive(input vec_t t);
    id++;
    for (int i = 0; i < t.n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ts = t.ts; es = t.es; bz = t.bz; fi = t.f; ox = t.ox; oy = t.oy;
      {up, dn, lf, rt} = t.dirs;
      sb.push_back('{t.ed, t.exp, id});
    end
  endtask
  always @(negedge clk)
    while (sb.size() > 0) begin
      s = sb.pop_front();
      act = s.ed ? {bx, by, bd, bf, bm} : {ax, ay, ad, af, am};
      checks++;
      if (act !== s.exp) begin
        failures++;
        $display("FAIL vec%0d %s: got x=%0d y=%0d dir=%0d fire=%b mov=%b, want x=%0d y=%0d dir=%0d fire=%b mov=%b",
                 s.id, s.ed ? "edge" : "main", act[15:10], act[9:4], act[3:2], act[1], act[0],
                 s.exp[15:10], s.exp[9:4], s.exp[3:2], s.exp[1], s.exp[0]);
      end
    end
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    tbl.push_back(v(8, PL, TI, 0, NO, 0, 20, 20, 0, e(2, 2, DIR_DOWN, 0, 0)));
    tbl.push_back(v(5, PL, TI, 0, R, 0, 20, 20, 0, e(2, 2, DIR_DOWN, 0, 0)));
    tbl.push_back(v(1, PL, TI, 0, R, 0, 20, 20, 0, e(2, 2, DIR_DOWN, 0, 1)));
    tbl.push_back(v(3, PL, TI, 0, R, 0, 20, 20, 0, e(2, 2, DIR_RIGHT, 0, 0)));
    tbl.push_back(v(1, PL, TI, 0, R, 0, 20, 20, 0, e(2, 2, DIR_RIGHT, 0, 1)));
    tbl.push_back(v(3, PL, TI, 0, R, 0, 20, 20, 0, e(3, 2, DIR_RIGHT, 0, 0)));
    tbl.push_back(v(1, PL, TI, 0, R, 0, 20, 20, 0, e(3, 2, DIR_RIGHT, 0, 1)));
    tbl.push_back(v(1, PL, TI, 0, R, 0, 20, 20, 0, e(4, 2, DIR_RIGHT, 0, 0)));
    tbl.push_back(v(1, TI, TI, 0, R, 0, 20, 20, 0, e(4, 2, DIR_RIGHT, 0, 0)));
    tbl.push_back(v(5, PL, TI, 0, R, 0, 5, 2, 0, e(2, 2, DIR_DOWN, 0, 0)));
    tbl.push_back(v(1, PL, TI, 0, R, 0, 5, 2, 0, e(2, 2, DIR_DOWN, 0, 1)));
    tbl.push_back(v(3, PL, TI, 0, R, 0, 5, 2, 0, e(2, 2, DIR_RIGHT, 0, 0)));
    tbl.push_back(v(1, PL, TI, 0, R, 0, 5, 2, 0, e(2, 2, DIR_RIGHT, 0, 1)));
    tbl.push_back(v(6, PL, TI, 0, R, 0, 5, 2, 0, e(3, 2, DIR_RIGHT, 0, 0)));
    @(posedge clk);
    #1;
    checks++;
    if ({ax, ay, ad, af, am} !== e(2, 2, DIR_DOWN, 0, 0) || {bx, by, bd, bf, bm} !== e(38, 2, DIR_RIGHT, 0, 0)) begin
      failures++;
      $display("FAIL reset state: main=%h edge=%h", {ax, ay, ad, af, am}, {bx, by, bd, bf, bm});
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      sb.push_back('{1'b0, e(2, 2, DIR_DOWN, 0, 0), 0});
      sb.push_back('{1'b1, e(38, 2, DIR_RIGHT, 0, 0), 0});
    end
    foreach (tbl[i]) drive(tbl[i]);
    drive(v(4, PL, TI, 0, D, 0, 20, 20, 0, e(3, 2, DIR_RIGHT, 0, 0)));
    drive(v(7, PL, TI, 1, NO, 0, 20, 20, 0, e(3, 2, DIR_RIGHT, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_RIGHT, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_RIGHT, 0, 1)));
    drive(v(2, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 1, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 1, 0)));
    drive(v(1, PL, TI, 0, NO, 1, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 1, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(3, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 1, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 1, 20, 20, 0, e(3, 2, DIR_DOWN, 1, 0)));
    drive(v(2, PL, TI, 0, NO, 1, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(3, PL, TI, 0, L, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PA, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, PA, TI, 0, NO, 1, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(2, PA, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(4, PL, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(1, TI, TI, 0, NO, 0, 20, 20, 0, e(3, 2, DIR_DOWN, 0, 0)));
    drive(v(2, TI, TI, 0, NO, 0, 20, 20, 0, e(2, 2, DIR_DOWN, 0, 0)));
    drive(v(5, TI, PL, 0, R, 0, 20, 20, 1, e(38, 2, DIR_RIGHT, 0, 0)));
    drive(v(1, TI, PL, 0, R, 0, 20, 20, 1, e(38, 2, DIR_RIGHT, 0, WRAP)));
    drive(v(2, TI, PL, 0, R, 0, 20, 20, 1, e(WRAP ? 0 : 38, 2, DIR_RIGHT, 0, 0)));
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
